// File: rtl/axis_user_demux_n.sv
// N-channel AXI-Stream packet demultiplexer: routes whole packets by the lowest set
// tuser bit of the first beat, drops unroutable or link-inactive packets and counts them.

package pcie_dl_pkg;
  typedef enum logic [1:0] {
    DL_INACTIVE = 2'd0,
    DL_INIT     = 2'd1,
    DL_ACTIVE   = 2'd2
  } pcie_dl_status_e;
endpackage

module axis_user_demux_n #(
  parameter int DATA_WIDTH     = 32,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int USER_WIDTH     = 2,
  parameter int NUM_CH         = 2,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  pcie_dl_pkg::pcie_dl_status_e       link_status_i,
  input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]              s_axis_tkeep,
  input  logic                               s_axis_tvalid,
  input  logic                               s_axis_tlast,
  input  logic [USER_WIDTH-1:0]              s_axis_tuser,
  output logic                               s_axis_tready,
  output logic [NUM_CH*DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [NUM_CH*KEEP_WIDTH-1:0]       m_axis_tkeep,
  output logic [NUM_CH-1:0]                  m_axis_tvalid,
  output logic [NUM_CH-1:0]                  m_axis_tlast,
  output logic [NUM_CH*USER_WIDTH-1:0]       m_axis_tuser,
  input  logic [NUM_CH-1:0]                  m_axis_tready,
  output logic [DROP_CNT_WIDTH-1:0]          drop_count_o,
  output logic                               busy_o
);

  // state   | meaning
  // ST_IDLE | waiting for the first beat of a packet; routes it
  // ST_FWD  | forwarding the rest of a packet to channel sel_q
  // ST_DROP | discarding the rest of an unroutable packet
  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_e;

  localparam int SEL_W = $clog2(NUM_CH);

  state_e                    state_q, state_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic [SEL_W-1:0]          route_idx, fwd_idx;
  logic                      route_found, fwd_valid, drop_start, s_ready;
  logic [NUM_CH-1:0]         ch_in_valid, ch_in_ready;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

  always_comb begin
    route_found = 1'b0;
    route_idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (s_axis_tuser[k]) begin
        route_found = 1'b1;
        route_idx   = SEL_W'(k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    s_ready    = 1'b0;
    fwd_valid  = 1'b0;
    fwd_idx    = sel_q;
    drop_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_axis_tvalid) begin
          if (route_found && (link_status_i == pcie_dl_pkg::DL_ACTIVE)) begin
            fwd_idx   = route_idx;
            fwd_valid = 1'b1;
            s_ready   = ch_in_ready[route_idx];
            if (s_ready && !s_axis_tlast) begin
              sel_d   = route_idx;
              state_d = ST_FWD;
            end
          end else begin
            s_ready    = 1'b1;
            drop_start = 1'b1;
            if (!s_axis_tlast) state_d = ST_DROP;
          end
        end
      end
      ST_FWD: begin
        fwd_valid = s_axis_tvalid;
        s_ready   = ch_in_ready[sel_q];
        if (s_axis_tvalid && s_ready && s_axis_tlast) state_d = ST_IDLE;
      end
      ST_DROP: begin
        s_ready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_axis_tready = rst_i & s_ready;
  assign busy_o        = (state_q != ST_IDLE);
  assign drop_count_o  = drop_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      if (drop_start && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + DROP_CNT_WIDTH'(1);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DATA_WIDTH-1:0] out_data_q, skid_data_q;
    logic [KEEP_WIDTH-1:0] out_keep_q, skid_keep_q;
    logic [USER_WIDTH-1:0] out_user_q, skid_user_q;
    logic                  out_last_q, skid_last_q;
    logic                  out_valid_q, skid_valid_q;
    logic                  acc;

    assign ch_in_valid[k] = fwd_valid && (fwd_idx == SEL_W'(k));
    assign ch_in_ready[k] = !skid_valid_q;
    assign acc            = ch_in_valid[k] && !skid_valid_q;

    // Upstream ready depends only on the registered skid flag, never on m_axis_tready.
    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        out_valid_q  <= 1'b0;
        skid_valid_q <= 1'b0;
      end else if (acc) begin
        if (!out_valid_q || m_axis_tready[k]) begin
          out_valid_q <= 1'b1;
          out_data_q  <= s_axis_tdata;
          out_keep_q  <= s_axis_tkeep;
          out_user_q  <= s_axis_tuser;
          out_last_q  <= s_axis_tlast;
        end else begin
          skid_valid_q <= 1'b1;
          skid_data_q  <= s_axis_tdata;
          skid_keep_q  <= s_axis_tkeep;
          skid_user_q  <= s_axis_tuser;
          skid_last_q  <= s_axis_tlast;
        end
      end else if (out_valid_q && m_axis_tready[k]) begin
        if (skid_valid_q) begin
          skid_valid_q <= 1'b0;
          out_data_q   <= skid_data_q;
          out_keep_q   <= skid_keep_q;
          out_user_q   <= skid_user_q;
          out_last_q   <= skid_last_q;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end

    assign m_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH] = out_data_q;
    assign m_axis_tkeep[k*KEEP_WIDTH +: KEEP_WIDTH] = out_keep_q;
    assign m_axis_tuser[k*USER_WIDTH +: USER_WIDTH] = out_user_q;
    assign m_axis_tvalid[k]                         = out_valid_q;
    assign m_axis_tlast[k]                          = out_last_q;
  end

endmodule

// File: tb/tb_axis_user_demux_n.sv
// Directed bench for axis_user_demux_n with four channels and a 2-bit drop counter.

module tb_axis_user_demux_n;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 4;
  localparam int NC = 4;
  localparam int CW = 2;

  logic                   clk = 1'b0;
  logic                   rst_i;
  pcie_dl_pkg::pcie_dl_status_e link;
  logic [DW-1:0]          s_tdata;
  logic [KW-1:0]          s_tkeep;
  logic                   s_tvalid, s_tlast, s_tready;
  logic [UW-1:0]          s_tuser;
  logic [NC*DW-1:0]       m_tdata;
  logic [NC*KW-1:0]       m_tkeep;
  logic [NC-1:0]          m_tvalid, m_tlast, m_tready;
  logic [NC*UW-1:0]       m_tuser;
  logic [CW-1:0]          drop;
  logic                   busy;

  axis_user_demux_n #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .NUM_CH(NC), .DROP_CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .link_status_i(link),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .drop_count_o(drop), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int acc_cyc_q[$];
  logic [34:0] got_q[$];
  logic [34:0] exp_q[$];
  int got_rd = 0;

  always @(posedge clk) cyc++;

  // Output handshakes, input acceptances and input stalls, all sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_i) begin
      for (int k = 0; k < NC; k++)
        if (m_tvalid[k] && m_tready[k])
          got_q.push_back({2'(k), m_tlast[k], m_tdata[k*DW +: DW]});
      if (s_tvalid && s_tready) acc_cyc_q.push_back(cyc);
      if (s_tvalid && !s_tready) stall_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input int ch, input bit last, input logic [31:0] d);
    exp_q.push_back({2'(ch), last, d});
  endtask

  task automatic check_q(input string tag);
    check_eq({tag, "_count"}, 64'(got_q.size() - got_rd), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (got_rd + i < got_q.size()) check_eq(tag, got_q[got_rd + i], exp_q[i]);
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] u, input bit last);
    int n = 0;
    s_tdata  = d;
    s_tkeep  = 4'hF;
    s_tuser  = u;
    s_tlast  = last;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("tready_wait", 64'(s_tready), 64'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  int base;
  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    rst_i    = 1'b0;
    link     = pcie_dl_pkg::DL_ACTIVE;
    s_tvalid = 1'b1;
    s_tuser  = 4'b0001;
    s_tdata  = '0;
    s_tkeep  = 4'hF;
    s_tlast  = 1'b1;
    m_tready = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tready", 64'(s_tready), 64'd0);
    check_eq("rst_tvalid", 64'(m_tvalid), 64'd0);
    check_eq("rst_drop", 64'(drop), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    s_tvalid = 1'b0;
    @(posedge clk);
    #1 rst_i = 1'b1;
    idle(1);

    // single-beat routing by lowest set tuser bit
    send_beat(32'hA0, 4'b0100, 1'b1);
    check_eq("route_ch2_valid", 64'(m_tvalid), 64'b0100);
    check_eq("route_ch2_data", 64'(m_tdata[2*DW +: DW]), 64'hA0);
    check_eq("route_ch2_user", 64'(m_tuser[2*UW +: UW]), 64'b0100);
    send_beat(32'hA1, 4'b0110, 1'b1);
    check_eq("route_ch1_valid", 64'(m_tvalid), 64'b0010);
    send_beat(32'hA2, 4'b1000, 1'b1);
    check_eq("route_ch3_valid", 64'(m_tvalid), 64'b1000);
    idle(2);
    exp_push(2, 1, 32'hA0);
    exp_push(1, 1, 32'hA1);
    exp_push(3, 1, 32'hA2);
    check_q("route");
    check_eq("route_drop", 64'(drop), 64'd0);

    // back-to-back multi-beat packets, later-beat tuser ignored
    base = acc_cyc_q.size();
    for (int i = 0; i < 5; i++) begin
      send_beat(32'h10 + 32'(i), (i == 0) ? 4'b0001 : 4'b1010, i == 4);
      if (i == 1) check_eq("fwd_busy", 64'(busy), 64'd1);
    end
    for (int i = 0; i < 3; i++) send_beat(32'h20 + 32'(i), 4'b0010, i == 2);
    idle(3);
    check_eq("nobubble_cnt", 64'(acc_cyc_q.size() - base), 64'd8);
    check_eq("nobubble_span", 64'(acc_cyc_q[acc_cyc_q.size()-1] - acc_cyc_q[base]), 64'd7);
    for (int i = 0; i < 5; i++) exp_push(0, i == 4, 32'h10 + 32'(i));
    for (int i = 0; i < 3; i++) exp_push(1, i == 2, 32'h20 + 32'(i));
    check_q("multibeat");
    check_eq("multibeat_busy", 64'(busy), 64'd0);

    // backpressure on channel 1 for four cycles
    base = stall_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) send_beat(32'h30 + 32'(i), 4'b0010, i == 5);
      end
      begin
        repeat (2) @(posedge clk);
        #1 m_tready[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1 m_tready[1] = 1'b1;
      end
    join
    idle(3);
    check_eq("bp_stalls", 64'(stall_cnt - base), 64'd4);
    for (int i = 0; i < 6; i++) exp_push(1, i == 5, 32'h30 + 32'(i));
    check_q("backpressure");

    // drop: no route
    base = acc_cyc_q.size();
    for (int i = 0; i < 3; i++) begin
      send_beat(32'hD0 + 32'(i), 4'b0000, i == 2);
      if (i == 0) check_eq("drop_busy", 64'(busy), 64'd1);
    end
    idle(2);
    check_eq("drop_acc", 64'(acc_cyc_q.size() - base), 64'd3);
    check_q("drop_noroute");
    check_eq("drop_cnt1", 64'(drop), 64'd1);

    // drop: link not active at packet start
    link = pcie_dl_pkg::DL_INACTIVE;
    send_beat(32'hE0, 4'b0001, 1'b0);
    send_beat(32'hE1, 4'b0001, 1'b1);
    link = pcie_dl_pkg::DL_ACTIVE;
    idle(2);
    check_q("drop_link");
    check_eq("drop_cnt2", 64'(drop), 64'd2);

    // link falls mid-packet: packet still completes
    send_beat(32'h40, 4'b0100, 1'b0);
    link = pcie_dl_pkg::DL_INACTIVE;
    send_beat(32'h41, 4'b0000, 1'b0);
    send_beat(32'h42, 4'b0000, 1'b1);
    link = pcie_dl_pkg::DL_ACTIVE;
    idle(2);
    for (int i = 0; i < 3; i++) exp_push(2, i == 2, 32'h40 + 32'(i));
    check_q("link_midpkt");
    check_eq("link_mid_drop", 64'(drop), 64'd2);

    // saturating drop counter
    rst_i = 1'b0;
    idle(1);
    rst_i = 1'b1;
    check_eq("sat_rst_drop", 64'(drop), 64'd0);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 1) link = pcie_dl_pkg::DL_INACTIVE;
      send_beat(32'h70 + 32'(i), (i % 2 == 1) ? 4'b0001 : 4'b0000, 1'b1);
      link = pcie_dl_pkg::DL_ACTIVE;
      check_eq("sat_drop", 64'(drop), 64'(sat_exp[i]));
    end
    idle(1);
    check_q("sat_none");

    // reset during beat 3 of 6 with both channels holding data
    m_tready = 4'b1100;
    send_beat(32'h50, 4'b0001, 1'b1);
    send_beat(32'h60, 4'b0010, 1'b0);
    send_beat(32'h61, 4'b0010, 1'b0);
    check_eq("hold_valid", 64'(m_tvalid), 64'b0011);
    s_tdata  = 32'h62;
    s_tuser  = 4'b1000;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    rst_i    = 1'b0;
    @(negedge clk);
    check_eq("midrst_tready", 64'(s_tready), 64'd0);
    @(posedge clk);
    #1 rst_i = 1'b1;
    m_tready = '1;
    check_eq("midrst_tvalid", 64'(m_tvalid), 64'd0);
    check_eq("midrst_drop", 64'(drop), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_q("midrst_flush");
    send_beat(32'h62, 4'b1000, 1'b0);
    check_eq("midrst_reroute", 64'(m_tvalid), 64'b1000);
    send_beat(32'h63, 4'b0010, 1'b0);
    send_beat(32'h64, 4'b0001, 1'b0);
    send_beat(32'h65, 4'b0010, 1'b1);
    idle(3);
    for (int i = 0; i < 4; i++) exp_push(3, i == 3, 32'h62 + 32'(i));
    check_q("midrst_tail");
    check_eq("midrst_end_drop", 64'(drop), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
